directory_home_controller: RTL and testbench

Home-node directory controller: the responder for the per-cache coherence FSMs, which issue read miss, write miss, invalidate and write-back messages. It owns the directory state and sharer vector for every block in its memory slice, and serialises one request at a time. For each request it sends fetch/invalidate messages to remote caches, collects their acks, updates the directory, then returns a reply to the requester. It sits between the node request network and the memory slice.

---
 rtl/directory_home_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_directory_home_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/directory_home_controller.sv
// -----------------------------------------------------------------------------
// directory_home_controller
//
// Home-node directory controller for one memory slice. It accepts one
// coherence request at a time from the node request network (read miss, write
// miss, upgrade, write-back). For each request it looks up the directory entry,
// sends FETCH / INVALIDATE / FETCH_INV messages to the remote caches that hold
// the block, waits for one ack per message, updates the entry and then replies
// to the requester.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_type, req_node, req_block     00 WB, 01 READ_MISS, 10 WRITE_MISS, 11 UPGRADE
//   msg_valid/msg_ready               message to a remote cache
//   msg_type, msg_node, msg_block     01 FETCH, 10 INVALIDATE, 11 FETCH_INV
//   ack_valid                         one ack per message sent
//   rep_valid/rep_ready               reply handshake
//   rep_node, rep_block, rep_data     rep_data 1 = data reply, 0 = ack only
//   dir_busy                          high whenever the FSM is not IDLE
//   stat_req, stat_inv                only with DIR_STATS_EN: saturating
//                                     counts of accepted requests and of
//                                     INVALIDATE + FETCH_INV handshakes
//
// Optional feature macro: DIR_STATS_EN
// -----------------------------------------------------------------------------
module directory_home_controller #(
  parameter int NODES  = 4,
  parameter int BLOCKS = 16,
  localparam int NW = $clog2(NODES),
  localparam int BW = $clog2(BLOCKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_type,
  input  logic [NW-1:0] req_node,
  input  logic [BW-1:0] req_block,
  output logic          msg_valid,
  input  logic          msg_ready,
  output logic [1:0]    msg_type,
  output logic [NW-1:0] msg_node,
  output logic [BW-1:0] msg_block,
  input  logic          ack_valid,
  output logic          rep_valid,
  input  logic          rep_ready,
  output logic [NW-1:0] rep_node,
  output logic [BW-1:0] rep_block,
  output logic          rep_data,
`ifdef DIR_STATS_EN
  output logic [15:0]   stat_req,
  output logic [15:0]   stat_inv,
`endif
  output logic          dir_busy
);

  localparam logic [1:0] REQ_WB  = 2'b00;
  localparam logic [1:0] REQ_RM  = 2'b01;
  localparam logic [1:0] REQ_WM  = 2'b10;
  localparam logic [1:0] REQ_UPG = 2'b11;

  localparam logic [1:0] MSG_FETCH     = 2'b01;
  localparam logic [1:0] MSG_INV       = 2'b10;
  localparam logic [1:0] MSG_FETCH_INV = 2'b11;

  localparam logic [1:0] ST_INVALID = 2'b01;
  localparam logic [1:0] ST_SHARED  = 2'b10;
  localparam logic [1:0] ST_MOD     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_SEND   = 3'd2,
    S_WAIT   = 3'd3,
    S_REPLY  = 3'd4
  } fsmState_t;

  fsmState_t state_r, stateNext_s;

  logic                             outEn_r;
  logic [1:0]                       reqType_r;
  logic [NW-1:0]                    reqNode_r;
  logic [BW-1:0]                    reqBlock_r;
  logic [NODES-1:0]                 target_r;
  logic [1:0]                       msgType_r;
  logic                             repData_r;
  logic [NW-1:0]                    scanIdx_r;
  logic [NW:0]                      pending_r;
  logic [BLOCKS-1:0][1:0]           dirState_r;
  logic [BLOCKS-1:0][NODES-1:0]     dirSharers_r;

  logic [1:0]       curState_s;
  logic [NODES-1:0] curSharers_s;
  logic [NODES-1:0] reqBit_s;
  logic             isOwner_s;
  logic             isSharer_s;
  logic [1:0]       lkState_s;
  logic [NODES-1:0] lkSharers_s;
  logic [NODES-1:0] lkTarget_s;
  logic [1:0]       lkMsgType_s;
  logic             lkRepData_s;
  logic             reqFire_s;
  logic             msgFire_s;
  logic             ackTake_s;
  logic             scanAdvance_s;
  logic             scanDone_s;
  logic             dirWrite_s;

  // Entry under lookup and requester decode. The directory is only written on
  // entry to REPLY, so these stay valid for the whole transaction.
  always_comb begin
    curState_s   = dirState_r[reqBlock_r];
    curSharers_s = dirSharers_r[reqBlock_r];
    reqBit_s     = '0;
    reqBit_s[reqNode_r] = 1'b1;
    isOwner_s    = (curState_s == ST_MOD) && (curSharers_s == reqBit_s);
    isSharer_s   = |(curSharers_s & reqBit_s);
  end

  // Protocol table: new entry, message targets, message type and reply kind.
  always_comb begin
    lkState_s   = curState_s;
    lkSharers_s = curSharers_s;
    lkTarget_s  = '0;
    lkMsgType_s = MSG_INV;
    lkRepData_s = 1'b1;
    case (reqType_r)
      REQ_WB: begin
        lkRepData_s = 1'b0;
        if (isOwner_s) begin
          lkState_s   = ST_INVALID;
          lkSharers_s = '0;
        end else begin
          lkState_s   = curState_s;
        end
      end
      REQ_RM: begin
        if (curState_s == ST_MOD) begin
          if (isOwner_s) begin
            lkSharers_s = reqBit_s;
          end else begin
            lkTarget_s  = curSharers_s;
            lkMsgType_s = MSG_FETCH;
            lkState_s   = ST_SHARED;
            lkSharers_s = curSharers_s | reqBit_s;
          end
        end else if (curState_s == ST_SHARED) begin
          lkSharers_s = curSharers_s | reqBit_s;
        end else begin
          lkState_s   = ST_SHARED;
          lkSharers_s = reqBit_s;
        end
      end
      REQ_WM, REQ_UPG: begin
        lkState_s   = ST_MOD;
        lkSharers_s = reqBit_s;
        if (curState_s == ST_MOD) begin
          if (isOwner_s) begin
            // Already the owner: an upgrade needs no data back.
            lkRepData_s = (reqType_r != REQ_UPG);
          end else begin
            lkTarget_s  = curSharers_s;
            lkMsgType_s = MSG_FETCH_INV;
          end
        end else if (curState_s == ST_SHARED) begin
          lkTarget_s  = curSharers_s;
          lkMsgType_s = MSG_INV;
          // Upgrade from a current sharer keeps its data; otherwise it is a
          // plain write miss and gets data.
          lkRepData_s = !((reqType_r == REQ_UPG) && isSharer_s);
        end else begin
          lkTarget_s  = '0;
        end
      end
      default: begin
        lkState_s = curState_s;
      end
    endcase
    // The requester never receives a message about its own request.
    lkTarget_s = lkTarget_s & ~reqBit_s;
  end

  assign reqFire_s     = req_valid && req_ready;
  assign msgFire_s     = msg_valid && msg_ready;
  assign ackTake_s     = ack_valid && (pending_r != '0);
  assign scanAdvance_s = !target_r[scanIdx_r] || msg_ready;
  assign scanDone_s    = scanAdvance_s && (scanIdx_r == NW'(NODES - 1));
  assign dirWrite_s    = (stateNext_s == S_REPLY) && (state_r != S_REPLY);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (reqFire_s) stateNext_s = S_LOOKUP;
        else           stateNext_s = S_IDLE;
      end
      S_LOOKUP: begin
        if (lkTarget_s != '0) stateNext_s = S_SEND;
        else                  stateNext_s = S_REPLY;
      end
      S_SEND: begin
        if (scanDone_s) stateNext_s = S_WAIT;
        else            stateNext_s = S_SEND;
      end
      S_WAIT: begin
        if (pending_r == '0) stateNext_s = S_REPLY;
        else                 stateNext_s = S_WAIT;
      end
      S_REPLY: begin
        if (rep_ready) stateNext_s = S_IDLE;
        else           stateNext_s = S_REPLY;
      end
      default: stateNext_s = S_IDLE;
    endcase
  end

  // FSM outputs; every field is zero while its valid is low.
  always_comb begin
    if (state_r == S_IDLE) req_ready = outEn_r;
    else                   req_ready = 1'b0;
    if ((state_r == S_SEND) && target_r[scanIdx_r]) begin
      msg_valid = 1'b1;
      msg_type  = msgType_r;
      msg_node  = scanIdx_r;
      msg_block = reqBlock_r;
    end else begin
      msg_valid = 1'b0;
      msg_type  = 2'b00;
      msg_node  = '0;
      msg_block = '0;
    end
    if (state_r == S_REPLY) begin
      rep_valid = 1'b1;
      rep_node  = reqNode_r;
      rep_block = reqBlock_r;
      rep_data  = repData_r;
    end else begin
      rep_valid = 1'b0;
      rep_node  = '0;
      rep_block = '0;
      rep_data  = 1'b0;
    end
    dir_busy = (state_r != S_IDLE);
  end

  // Holds req_ready low through the reset cycles themselves.
  always_ff @(posedge clk) begin
    if (!rst_n) outEn_r <= 1'b0;
    else        outEn_r <= 1'b1;
  end

  // Request latch on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reqType_r  <= 2'b00;
      reqNode_r  <= '0;
      reqBlock_r <= '0;
    end else if (reqFire_s) begin
      reqType_r  <= req_type;
      reqNode_r  <= req_node;
      reqBlock_r <= req_block;
    end
  end

  // Lookup results captured for the SEND and REPLY phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_r  <= '0;
      msgType_r <= 2'b00;
      repData_r <= 1'b0;
    end else if (state_r == S_LOOKUP) begin
      target_r  <= lkTarget_s;
      msgType_r <= lkMsgType_s;
      repData_r <= lkRepData_s;
    end
  end

  // Node scan pointer: one index per cycle, stalled on an unaccepted message.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scanIdx_r <= '0;
    end else if (state_r == S_LOOKUP) begin
      scanIdx_r <= '0;
    end else if ((state_r == S_SEND) && scanAdvance_s) begin
      scanIdx_r <= scanIdx_r + {{(NW-1){1'b0}}, 1'b1};
    end
  end

  // Outstanding ack counter; acks with nothing outstanding are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= '0;
    end else begin
      case ({msgFire_s, ackTake_s})
        2'b10:   pending_r <= pending_r + {{NW{1'b0}}, 1'b1};
        2'b01:   pending_r <= pending_r - {{NW{1'b0}}, 1'b1};
        default: pending_r <= pending_r;
      endcase
    end
  end

  // Directory storage, updated once per transaction on entry to REPLY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCKS; i++) begin
        dirState_r[i]   <= ST_INVALID;
        dirSharers_r[i] <= '0;
      end
    end else if (dirWrite_s) begin
      dirState_r[reqBlock_r]   <= lkState_s;
      dirSharers_r[reqBlock_r] <= lkSharers_s;
    end
  end

`ifdef DIR_STATS_EN
  logic [15:0] statReq_r;
  logic [15:0] statInv_r;

  // Saturating request and invalidation counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      statReq_r <= 16'd0;
      statInv_r <= 16'd0;
    end else begin
      if (reqFire_s && (statReq_r != 16'hFFFF)) statReq_r <= statReq_r + 16'd1;
      if (msgFire_s && (msgType_r != MSG_FETCH) && (statInv_r != 16'hFFFF))
        statInv_r <= statInv_r + 16'd1;
    end
  end

  assign stat_req = statReq_r;
  assign stat_inv = statInv_r;
`endif

endmodule

// File: tb/tb_directory_home_controller.sv
module tb_directory_home_controller;

  localparam logic [1:0] WB = 2'b00, RM = 2'b01, WM = 2'b10, UPG = 2'b11;
  localparam logic [1:0] FETCH = 2'b01, INV = 2'b10, FINV = 2'b11;
  localparam logic [1:0] SI = 2'b01, SS = 2'b10, SM = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_type = 2'b00;
  logic [1:0] req_node = 2'b00;
  logic [3:0] req_block = 4'd0;
  logic       msg_valid, msg_ready = 1'b0;
  logic [1:0] msg_type, msg_node;
  logic [3:0] msg_block;
  logic       ack_valid = 1'b0;
  logic       rep_valid, rep_ready = 1'b0;
  logic [1:0] rep_node;
  logic [3:0] rep_block;
  logic       rep_data, dir_busy;
`ifdef DIR_STATS_EN
  logic [15:0] stat_req, stat_inv;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed { logic [1:0] t; logic [1:0] n; logic [3:0] b; } msg_t;
  typedef struct packed { logic [1:0] n; logic [3:0] b; logic d; } rep_t;
  msg_t msgQ[$];
  rep_t repQ[$];

  directory_home_controller dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_node(req_node), .req_block(req_block),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
    .msg_node(msg_node), .msg_block(msg_block),
    .ack_valid(ack_valid),
    .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_node(rep_node),
    .rep_block(rep_block), .rep_data(rep_data),
`ifdef DIR_STATS_EN
    .stat_req(stat_req), .stat_inv(stat_inv),
`endif
    .dir_busy(dir_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushMsg(input logic [1:0] t, input logic [1:0] n, input logic [3:0] b);
    msgQ.push_back('{t: t, n: n, b: b});
  endtask

  task automatic pushRep(input logic [1:0] n, input logic [3:0] b, input logic d);
    repQ.push_back('{n: n, b: b, d: d});
  endtask

  task automatic checkEntry(input int b, input logic [1:0] st, input logic [3:0] sh);
    check($sformatf("entry%0d_state", b), dut.dirState_r[b], st);
    check($sformatf("entry%0d_sharers", b), dut.dirSharers_r[b], sh);
  endtask

  // Issue one request, serve messages (with optional msg_ready stall), ack
  // each message, and compare everything against the scoreboard queues.
  task automatic transact(input logic [1:0] t, input logic [1:0] n, input logic [3:0] b,
                          input int stall, input int expLat);
    int c0 = 0;
    int acks = 0;
    int st = stall;
    logic done = 1'b0;
    msg_t em;
    rep_t er;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        req_type = t; req_node = n; req_block = b; req_valid = 1'b1;
        c0 = cyc; done = 1'b1;
      end
    end
    check("req_accept", done, 1'b1);
    @(posedge clk);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      req_valid = 1'b0; msg_ready = 1'b0; rep_ready = 1'b0; ack_valid = 1'b0;
      if (acks > 0) begin ack_valid = 1'b1; acks--; end
      if (msg_valid) begin
        if (msgQ.size() == 0) begin
          check("msg_unexpected", msg_valid, 1'b0);
          msg_ready = 1'b1; acks++;
        end else begin
          em = msgQ[0];
          check("msg_type", msg_type, em.t);
          check("msg_node", msg_node, em.n);
          check("msg_block", msg_block, em.b);
          if (st > 0) st--;
          else begin msg_ready = 1'b1; void'(msgQ.pop_front()); acks++; end
        end
      end
      if (rep_valid) begin
        if (repQ.size() == 0) begin
          check("rep_unexpected", rep_valid, 1'b0);
        end else begin
          er = repQ.pop_front();
          check("rep_node", rep_node, er.n);
          check("rep_block", rep_block, er.b);
          check("rep_data", rep_data, er.d);
          check("msgs_all_sent", msgQ.size(), 0);
          if (expLat >= 0) check("rep_latency", cyc - c0, expLat);
        end
        rep_ready = 1'b1; done = 1'b1;
      end
    end
    check("rep_timeout", done, 1'b1);
    @(negedge clk);
    rep_ready = 1'b0; msg_ready = 1'b0; ack_valid = 1'b0;
    check("ready_after_reply", req_ready, 1'b1);
    check("busy_after_reply", dir_busy, 1'b0);
    msgQ.delete();
    repQ.delete();
  endtask

  initial begin
    logic seen;
    // Reset: outputs all zero while rst_n is low.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_msg_valid", msg_valid, 1'b0);
    check("rst_rep_valid", rep_valid, 1'b0);
    check("rst_dir_busy", dir_busy, 1'b0);
    check("rst_rep_data", rep_data, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);
    checkEntry(3, SI, 4'b0000);

    // READ_MISS on an uncached block: no messages, reply at t+2.
    pushRep(2'd1, 4'd3, 1'b1);
    transact(RM, 2'd1, 4'd3, 0, 2);
    checkEntry(3, SS, 4'b0010);

    // Three readers, then node 2 upgrades: invalidate 0 then 3.
    pushRep(2'd0, 4'd5, 1'b1); transact(RM, 2'd0, 4'd5, 0, 2);
    pushRep(2'd2, 4'd5, 1'b1); transact(RM, 2'd2, 4'd5, 0, 2);
    pushRep(2'd3, 4'd5, 1'b1); transact(RM, 2'd3, 4'd5, 0, 2);
    checkEntry(5, SS, 4'b1101);
    pushMsg(INV, 2'd0, 4'd5); pushMsg(INV, 2'd3, 4'd5);
    pushRep(2'd2, 4'd5, 1'b0);
    transact(UPG, 2'd2, 4'd5, 0, -1);
    checkEntry(5, SM, 4'b0100);

    // Block 7 owned by node 3, then node 1 write-misses with msg_ready stalled.
    pushRep(2'd3, 4'd7, 1'b1); transact(WM, 2'd3, 4'd7, 0, 2);
    checkEntry(7, SM, 4'b1000);
    pushMsg(FINV, 2'd3, 4'd7); pushRep(2'd1, 4'd7, 1'b1);
    transact(WM, 2'd1, 4'd7, 3, -1);
    checkEntry(7, SM, 4'b0010);

    // Read miss on a block owned elsewhere fetches from the owner.
    pushMsg(FETCH, 2'd1, 4'd7); pushRep(2'd0, 4'd7, 1'b1);
    transact(RM, 2'd0, 4'd7, 0, -1);
    checkEntry(7, SS, 4'b0011);

    // Write-backs: by the owner, then a stale one from a non-owner.
    pushRep(2'd2, 4'd9, 1'b1); transact(WM, 2'd2, 4'd9, 0, 2);
    pushRep(2'd2, 4'd9, 1'b0); transact(WB, 2'd2, 4'd9, 0, 2);
    checkEntry(9, SI, 4'b0000);
    pushRep(2'd1, 4'd9, 1'b0); transact(WB, 2'd1, 4'd9, 0, 2);
    checkEntry(9, SI, 4'b0000);

    // Reset while waiting for an ack.
    @(negedge clk);
    req_type = WM; req_node = 2'd0; req_block = 4'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (msg_valid) seen = 1'b1;
    end
    check("abort_msg_seen", seen, 1'b1);
    check("abort_msg_type", msg_type, INV);
    check("abort_msg_node", msg_node, 2'd1);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", dir_busy, 1'b1);
    check("abort_pending", dut.pending_r, 3'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1'b0);
    check("abort_msg_valid", msg_valid, 1'b0);
    check("abort_rep_valid", rep_valid, 1'b0);
    check("abort_dir_busy", dir_busy, 1'b0);
    check("abort_rep_data", rep_data, 1'b0);
    check("abort_fields", {msg_type, msg_node, msg_block, rep_node, rep_block}, 14'd0);
    for (int b = 0; b < 16; b++) checkEntry(b, SI, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", req_ready, 1'b1);
    ack_valid = 1'b1;
    @(negedge clk);
    ack_valid = 1'b0;
    check("stray_ack_pending", dut.pending_r, 3'd0);
    check("stray_ack_busy", dir_busy, 1'b0);
`ifdef DIR_STATS_EN
    check("stat_req_reset", stat_req, 16'd0);
    check("stat_inv_reset", stat_inv, 16'd0);
`endif

    // Three requests, the last invalidating two sharers.
    pushRep(2'd0, 4'd1, 1'b1); transact(RM, 2'd0, 4'd1, 0, 2);
    pushRep(2'd1, 4'd1, 1'b1); transact(RM, 2'd1, 4'd1, 0, 2);
    pushMsg(INV, 2'd0, 4'd1); pushMsg(INV, 2'd1, 4'd1); pushRep(2'd2, 4'd1, 1'b1);
    transact(WM, 2'd2, 4'd1, 0, -1);
    checkEntry(1, SM, 4'b0100);
`ifdef DIR_STATS_EN
    check("stat_req", stat_req, 16'd3);
    check("stat_inv", stat_inv, 16'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
